// File: rtl/sreg_bidir_tx_pkg.sv
// Shared definitions for the bidirectional shift-register transmit controller.
// Optional parity frame bit is selected with SREG_BIDIR_TX_PARITY_EN.
package sreg_bidir_tx_pkg;

  localparam int SREG_NBITS = 8;

  // Shift direction as seen on the register's op input
  localparam logic DIR_LEFT  = 1'b0;  // MSB-first
  localparam logic DIR_RIGHT = 1'b1;  // LSB-first

  // Count value while the final data bit is on the wire
  localparam logic [3:0] CNT_LAST = 4'(SREG_NBITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_e;

endpackage

// File: rtl/sreg_bidir_tx_bitcnt.sv
// Data-bit counter for one frame: cleared on byte accept, advanced on each
// serial transfer; flags the last data bit.
module sreg_bidir_tx_bitcnt
  import sreg_bidir_tx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_last_o
);

  logic [3:0] cnt_q, cnt_d;

  // Clear wins over increment so a new frame always starts at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = 4'd0;
    else if (inc_i) cnt_d = cnt_q + 4'd1;
  end

  // Count register, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign at_last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/sreg_bidir_tx_ctrl.sv
// Byte-to-bit serializer controller driving an external 8-bit bidirectional
// shift register. Accepts a byte + direction, loads the register, then emits
// one bit per transfer from the register's end bit.
// Define SREG_BIDIR_TX_PARITY_EN to append an even-parity bit to each frame.
module sreg_bidir_tx_ctrl
  import sreg_bidir_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [SREG_NBITS-1:0] in_data,
  input  logic                  in_dir,
  output logic                  sreg_ld,
  output logic                  sreg_en,
  output logic                  sreg_op,
  output logic [SREG_NBITS-1:0] sreg_pin,
  input  logic [SREG_NBITS-1:0] sreg_pout,
  output logic                  sout_val,
  input  logic                  sout_rdy,
  output logic                  sout,
  output logic                  sout_last,
  output logic                  busy
);

  state_e state_q, state_d;
  logic   dir_q, dir_d;
  logic   st_idle, st_shift, st_par;
  logic   accept, xfer, at_last, shift_bit;

  // Only the two end bits of pout are ever observed
  logic unused_pout;
  assign unused_pout = &{1'b0, sreg_pout[SREG_NBITS-2:1]};

  // State decodes are gated by reset so every handshake output is low
  // while reset is held, even if reset lands mid-frame.
  assign st_idle  = !reset && (state_q == ST_IDLE);
  assign st_shift = !reset && (state_q == ST_SHIFT);
`ifdef SREG_BIDIR_TX_PARITY_EN
  assign st_par   = !reset && (state_q == ST_PAR);
`else
  assign st_par   = 1'b0;
`endif

  assign accept    = st_idle && in_val;
  assign xfer      = st_shift && sout_rdy;
  assign shift_bit = (dir_q == DIR_RIGHT) ? sreg_pout[0] : sreg_pout[SREG_NBITS-1];

  sreg_bidir_tx_bitcnt u_bitcnt (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (accept),
    .inc_i     (xfer),
    .at_last_o (at_last)
  );

`ifdef SREG_BIDIR_TX_PARITY_EN
  logic par_q, par_d;

  // Running XOR of transmitted data bits, restarted per frame
  always_comb begin
    par_d = par_q;
    if (accept)    par_d = 1'b0;
    else if (xfer) par_d = par_q ^ shift_bit;
  end

  // Parity accumulator register
  always_ff @(posedge clk) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

  // Frame sequencing: IDLE -> SHIFT (8 bits) [-> PAR] -> IDLE
  always_comb begin
    state_d = state_q;
    dir_d   = accept ? in_dir : dir_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (xfer && at_last) begin
`ifdef SREG_BIDIR_TX_PARITY_EN
        state_d = ST_PAR;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef SREG_BIDIR_TX_PARITY_EN
      ST_PAR:   if (sout_rdy) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and direction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  // Outputs: load is combinational off the accept so the register captures
  // the byte on the same edge that moves us into SHIFT.
  assign in_rdy   = st_idle;
  assign sreg_ld  = accept;
  assign sreg_pin = accept ? in_data : '0;
  assign sreg_en  = xfer;  // register advances only on a completed transfer
  assign sreg_op  = st_shift ? dir_q : DIR_LEFT;
  assign sout_val = st_shift || st_par;
  assign busy     = !reset && (state_q != ST_IDLE);

`ifdef SREG_BIDIR_TX_PARITY_EN
  assign sout      = st_shift ? shift_bit : (st_par ? par_q : 1'b0);
  assign sout_last = st_par;
`else
  assign sout      = st_shift ? shift_bit : 1'b0;
  assign sout_last = st_shift && at_last;
`endif

endmodule
